// File: rtl/prio_sched_if.sv
// Valid/ready bundle between the HP/NP queue pair, the scheduler and the
// downstream consumer. The scheduler takes the master modport; the queue
// and consumer side takes the slave modport.
interface prio_sched_if #(
  parameter int DW = 33
);
  logic [DW-1:0] hp_data;
  logic          hp_vld;
  logic          hp_rdy;
  logic [DW-1:0] np_data;
  logic          np_vld;
  logic          np_rdy;
  logic [DW-1:0] data_out;
  logic          vld_o;
  logic          rdy_i;
  logic          src_o;

  modport master (
    input  hp_data, hp_vld, np_data, np_vld, rdy_i,
    output hp_rdy, np_rdy, data_out, vld_o, src_o
  );

  modport slave (
    output hp_data, hp_vld, np_data, np_vld, rdy_i,
    input  hp_rdy, np_rdy, data_out, vld_o, src_o
  );
endinterface

// File: rtl/prio_sched.sv
// Two-queue output scheduler. HP is preferred; an aging counter forces one
// NP grant after STARVE_LIMIT consecutive HP grants taken while NP waited.
// Output is a single registered stage that refills in the cycle it drains.
// Optional statistics counters are built when PRIO_SCHED_STATS_EN is
// defined; otherwise the statistics ports are tied to zero.
module prio_sched #(
  parameter int DW           = 33,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  prio_sched_if.master bus,
  output logic [15:0] hp_cnt,
  output logic [15:0] np_cnt,
  output logic [15:0] forced_cnt
);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_HP,
    GNT_NP
  } grant_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [DW-1:0] data_q, data_d;
  logic          vld_q, vld_d;
  logic          src_q, src_d;
  logic [7:0]    cnt_q, cnt_d;
  grant_e        grant;
  logic          forced;
  logic          load;

  // Output register may take a new word when empty or draining this cycle.
  assign load = !vld_q || bus.rdy_i;

  // Arbitration: pick a source and advance the aging counter.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant  = GNT_NONE;
    forced = 1'b0;
    cnt_d  = cnt_q;
    if (!rst && load) begin
      case ({bus.hp_vld, bus.np_vld})
        2'b11: begin
          if (cnt_q < LIMIT) begin
            grant = GNT_HP;
            cnt_d = cnt_q + 8'd1;
          end else begin
            grant  = GNT_NP;
            forced = 1'b1;
            cnt_d  = 8'd0;
          end
        end
        2'b10: begin
          grant = GNT_HP;
          cnt_d = 8'd0;
        end
        2'b01: begin
          grant = GNT_NP;
          cnt_d = 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Next state of the output stage: load the granted word, or empty it.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    src_d  = src_q;
    if (load) begin
      case (grant)
        GNT_HP: begin
          data_d = bus.hp_data;
          vld_d  = 1'b1;
          src_d  = 1'b1;
        end
        GNT_NP: begin
          data_d = bus.np_data;
          vld_d  = 1'b1;
          src_d  = 1'b0;
        end
        default: vld_d = 1'b0;
      endcase
    end
  end

  // Output stage and aging counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, and reset is
    // sampled on the clock edge rather than in the sensitivity list.
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      src_q  <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      src_q  <= src_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.hp_rdy   = (grant == GNT_HP);
  assign bus.np_rdy   = (grant == GNT_NP);
  assign bus.data_out = data_q;
  assign bus.vld_o    = vld_q;
  assign bus.src_o    = src_q;

`ifdef PRIO_SCHED_STATS_EN
  logic [15:0] hp_cnt_q, hp_cnt_d;
  logic [15:0] np_cnt_q, np_cnt_d;
  logic [15:0] forced_cnt_q, forced_cnt_d;

  // Saturating grant statistics; a forced grant also counts as an NP grant.
  always_comb begin
    hp_cnt_d     = hp_cnt_q;
    np_cnt_d     = np_cnt_q;
    forced_cnt_d = forced_cnt_q;
    if (grant == GNT_HP && hp_cnt_q != 16'hFFFF) hp_cnt_d = hp_cnt_q + 16'd1;
    if (grant == GNT_NP && np_cnt_q != 16'hFFFF) np_cnt_d = np_cnt_q + 16'd1;
    if (forced && forced_cnt_q != 16'hFFFF) forced_cnt_d = forced_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_cnt_q     <= 16'd0;
      np_cnt_q     <= 16'd0;
      forced_cnt_q <= 16'd0;
    end else begin
      hp_cnt_q     <= hp_cnt_d;
      np_cnt_q     <= np_cnt_d;
      forced_cnt_q <= forced_cnt_d;
    end
  end

  assign hp_cnt     = hp_cnt_q;
  assign np_cnt     = np_cnt_q;
  assign forced_cnt = forced_cnt_q;
`else
  assign hp_cnt     = 16'd0;
  assign np_cnt     = 16'd0;
  assign forced_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_prio_sched.sv
// Self-checking bench for prio_sched. Queue models feed the DUT, every pop
// pushes the expected word into a scoreboard, and every output transfer is
// compared against it. A per-cycle vector table checks arbitration; short
// hand-written sequences cover reset, starvation, NP-only, stall and
// reset-while-holding.
module tb_prio_sched;
  localparam int DW  = 33;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] hp_cnt, np_cnt, forced_cnt;

  always #5 clk = ~clk;

  prio_sched_if #(.DW(DW)) bus ();

  prio_sched #(.DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .hp_cnt     (hp_cnt),
    .np_cnt     (np_cnt),
    .forced_cnt (forced_cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          src;
  } exp_t;

  typedef struct {
    logic hp;
    logic np;
    logic rdy;
    logic exp_hp;
    logic exp_np;
  } vec_t;

  exp_t          sb[$];
  logic [DW-1:0] hpq[$];
  logic [DW-1:0] npq[$];
  logic          hp_en, np_en;
  logic          hp_pop, np_pop;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present the queue heads to the DUT.
  task automatic drive();
    bus.hp_vld  = hp_en && (hpq.size() > 0);
    bus.hp_data = (hpq.size() > 0) ? hpq[0] : '0;
    bus.np_vld  = np_en && (npq.size() > 0);
    bus.np_data = (npq.size() > 0) ? npq[0] : '0;
  endtask

  // Mid-cycle: record pops, score output transfers, queue expectations.
  task automatic at_neg();
    @(negedge clk);
    hp_pop = bus.hp_rdy;
    np_pop = bus.np_rdy;
    if (hp_pop || np_pop) check("rdy_onehot", 64'(hp_pop & np_pop), 64'(0));
    if (hp_pop) check("hp_rdy_needs_vld", 64'(bus.hp_vld), 64'(1));
    if (np_pop) check("np_rdy_needs_vld", 64'(bus.np_vld), 64'(1));
    if (bus.vld_o && bus.rdy_i) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", 64'(bus.vld_o), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 64'(bus.data_out), 64'(e.data));
        check("sb_src", 64'(bus.src_o), 64'(e.src));
      end
    end
    if (hp_pop && hpq.size() > 0) sb.push_back('{data: hpq[0], src: 1'b1});
    if (np_pop && npq.size() > 0) sb.push_back('{data: npq[0], src: 1'b0});
  endtask

  // After the edge: retire popped heads and refresh the inputs.
  task automatic at_pos();
    @(posedge clk);
    #1;
    if (rst) sb.delete();
    if (hp_pop && hpq.size() > 0) void'(hpq.pop_front());
    if (np_pop && npq.size() > 0) void'(npq.pop_front());
    hp_pop = 1'b0;
    np_pop = 1'b0;
    drive();
  endtask

  task automatic cycle();
    at_neg();
    at_pos();
  endtask

  task automatic clean_reset();
    hp_en = 1'b0;
    np_en = 1'b0;
    bus.rdy_i = 1'b1;
    drive();
    repeat (3) cycle();
    hpq.delete();
    npq.delete();
    drive();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[25];
    logic          src_seq[$];
    logic [9:0]    pat;
    int            hp_run;
    logic          done;

    // Cycle-by-cycle arbitration vectors, starting right after reset with
    // cnt=0 and the output register empty. Queues always hold words.
    vecs = '{
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 0  first grant HP, cnt=1
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 1  cnt=2
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 2  cnt=3
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0},  // 3  NP gone: HP, cnt=0
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 4  cnt=1
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 5  cnt=2
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 6  cnt=3
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 7  cnt=4
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1},  // 8  forced NP, cnt=0
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},  // 9  stall
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},  // 10 stall
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 11 cnt=1
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},  // 12 NP only, cnt=0
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},  // 13 nothing, output empties
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // 14 empty output, nothing valid
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0},  // 15 empty output loads despite rdy_i=0
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},  // 16 stall
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},  // 17 NP only, cnt=0
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 18 cnt=1
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},  // 19 nothing: cnt holds 1
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 20 cnt=2
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 21 cnt=3
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 22 cnt=4
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1},  // 23 forced NP
      '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}   // 24 drain
    };

    rst       = 1'b1;
    hp_pop    = 1'b0;
    np_pop    = 1'b0;
    bus.rdy_i = 1'b1;
    for (int i = 0; i < 32; i++) begin
      hpq.push_back({1'b1, 32'hA000_0000 + 32'(i)});
      npq.push_back({1'b0, 32'h5000_0000 + 32'(i)});
    end
    hp_en = 1'b1;
    np_en = 1'b1;
    drive();

    // Reset held with both sources valid: no pops, empty output.
    repeat (3) begin
      at_neg();
      check("rst_hp_rdy", 64'(bus.hp_rdy), 64'(0));
      check("rst_np_rdy", 64'(bus.np_rdy), 64'(0));
      check("rst_vld_o", 64'(bus.vld_o), 64'(0));
      check("rst_data_out", 64'(bus.data_out), 64'(0));
      at_pos();
    end
    rst = 1'b0;

    // Vector table; row 0 is the first cycle after reset falls.
    for (int i = 0; i < 25; i++) begin
      hp_en     = vecs[i].hp;
      np_en     = vecs[i].np;
      bus.rdy_i = vecs[i].rdy;
      drive();
      at_neg();
      check($sformatf("vec%0d_hp_rdy", i), 64'(bus.hp_rdy), 64'(vecs[i].exp_hp));
      check($sformatf("vec%0d_np_rdy", i), 64'(bus.np_rdy), 64'(vecs[i].exp_np));
      at_pos();
    end
    cycle();
    check("vec_sb_drained", 64'(sb.size()), 64'(0));

    // Starvation pattern from a fresh reset with 10 words in each queue.
    clean_reset();
    for (int i = 0; i < 10; i++) begin
      hpq.push_back({1'b1, 32'h0000_1000 + 32'(i)});
      npq.push_back({1'b0, 32'h0000_2000 + 32'(i)});
    end
    hp_en = 1'b1;
    np_en = 1'b1;
    drive();
    pat = 10'b1111011110;
    for (int c = 0; c < 20 && src_seq.size() < 10; c++) begin
      at_neg();
      if (bus.vld_o) src_seq.push_back(bus.src_o);
      if (src_seq.size() == 10) begin
`ifdef PRIO_SCHED_STATS_EN
        check("stats_hp_cnt", 64'(hp_cnt), 64'(8));
        check("stats_np_cnt", 64'(np_cnt), 64'(2));
        check("stats_forced_cnt", 64'(forced_cnt), 64'(2));
`else
        check("stats_hp_cnt", 64'(hp_cnt), 64'(0));
        check("stats_np_cnt", 64'(np_cnt), 64'(0));
        check("stats_forced_cnt", 64'(forced_cnt), 64'(0));
`endif
      end
      at_pos();
    end
    check("starve_out_count", 64'(src_seq.size()), 64'(10));
    for (int i = 0; i < src_seq.size() && i < 10; i++)
      check($sformatf("starve_src%0d", i), 64'(src_seq[i]), 64'(pat[9-i]));
    hp_en = 1'b0;
    np_en = 1'b0;
    drive();
    repeat (2) cycle();
    check("starve_sb_drained", 64'(sb.size()), 64'(0));

    // NP only: three words on consecutive cycles, aging counter stays 0.
    clean_reset();
    for (int i = 1; i <= 3; i++) npq.push_back(DW'(i));
    np_en = 1'b1;
    drive();
    at_neg();
    check("nponly_first_pop", 64'(bus.np_rdy), 64'(1));
    at_pos();
    for (int k = 1; k <= 3; k++) begin
      at_neg();
      check($sformatf("nponly_vld%0d", k), 64'(bus.vld_o), 64'(1));
      check($sformatf("nponly_data%0d", k), 64'(bus.data_out), 64'(k));
      check($sformatf("nponly_src%0d", k), 64'(bus.src_o), 64'(0));
      at_pos();
    end
    for (int i = 0; i < 8; i++) begin
      hpq.push_back({1'b1, 32'h0000_3000 + 32'(i)});
      npq.push_back({1'b0, 32'h0000_4000 + 32'(i)});
    end
    hp_en  = 1'b1;
    drive();
    hp_run = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      at_neg();
      if (bus.np_rdy) done = 1'b1;
      else if (bus.hp_rdy) hp_run++;
      at_pos();
    end
    check("nponly_forced_seen", 64'(done), 64'(1));
    check("nponly_hp_run", 64'(hp_run), 64'(LIM));
    hp_en = 1'b0;
    np_en = 1'b0;
    drive();
    repeat (2) cycle();

    // Downstream stall for 5 cycles holding 0x1_DEAD_BEEF.
    clean_reset();
    hpq.push_back(33'h1_DEAD_BEEF);
    hp_en     = 1'b1;
    bus.rdy_i = 1'b0;
    drive();
    at_neg();
    check("stall_first_pop", 64'(bus.hp_rdy), 64'(1));
    at_pos();
    hpq.push_back(33'h0_1234_5678);
    npq.push_back(33'h0_0BAD_F00D);
    np_en = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check($sformatf("stall%0d_data", k), 64'(bus.data_out), 64'(33'h1_DEAD_BEEF));
      check($sformatf("stall%0d_src", k), 64'(bus.src_o), 64'(1));
      check($sformatf("stall%0d_vld", k), 64'(bus.vld_o), 64'(1));
      check($sformatf("stall%0d_hp_rdy", k), 64'(bus.hp_rdy), 64'(0));
      check($sformatf("stall%0d_np_rdy", k), 64'(bus.np_rdy), 64'(0));
      at_pos();
    end
    bus.rdy_i = 1'b1;
    at_neg();
    check("stall_release_pop", 64'(bus.hp_rdy), 64'(1));
    at_pos();
    at_neg();
    check("stall_next_data", 64'(bus.data_out), 64'(33'h0_1234_5678));
    check("stall_next_src", 64'(bus.src_o), 64'(1));
    at_pos();
    hp_en = 1'b0;
    np_en = 1'b0;
    drive();
    repeat (2) cycle();

    // Reset while a word is held: word dropped, queue head re-sent.
    clean_reset();
    hpq.push_back(33'h1_0000_00AA);
    hpq.push_back(33'h0_0000_00BB);
    hp_en     = 1'b1;
    bus.rdy_i = 1'b0;
    drive();
    cycle();
    at_neg();
    check("rstmid_held_vld", 64'(bus.vld_o), 64'(1));
    check("rstmid_held_data", 64'(bus.data_out), 64'(33'h1_0000_00AA));
    at_pos();
    rst = 1'b1;
    at_neg();
    check("rstmid_no_pop", 64'(bus.hp_rdy), 64'(0));
    at_pos();
    rst       = 1'b0;
    bus.rdy_i = 1'b1;
    at_neg();
    check("rstmid_dropped_vld", 64'(bus.vld_o), 64'(0));
    check("rstmid_dropped_data", 64'(bus.data_out), 64'(0));
    check("rstmid_resend_pop", 64'(bus.hp_rdy), 64'(1));
    at_pos();
    at_neg();
    check("rstmid_resent_vld", 64'(bus.vld_o), 64'(1));
    check("rstmid_resent_data", 64'(bus.data_out), 64'(33'h0_0000_00BB));
    at_pos();
    hp_en = 1'b0;
    drive();
    repeat (2) cycle();
    check("final_sb_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
